// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM encoding and frame constants for parity_rx
package parity_pkg;

  localparam int DATA_W = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - XOR reduction of nibble plus parity bit against the configured sense
module parity_calc
  import parity_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  output logic              err
);

  assign err = ((^data) ^ parity) != PARITY_ODD;

endmodule

// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial start/4-data/parity/stop frame receiver; PARITY_RX_ERR_CNT_EN adds out_err_cnt
module parity_rx
  import parity_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_err_parity,
  output logic              out_err_frame,
  output logic              out_busy
`ifdef PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        out_err_cnt
`endif
);

  state_t            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              par_err;
  logic              stop_take;

  parity_calc #(.PARITY_ODD(PARITY_ODD)) u_calc (
    .data   (shreg),
    .parity (par),
    .err    (par_err)
  );

  // in_clr outranks in_valid, so only an unaborted consumed bit can close a frame
  assign stop_take = in_valid && !in_clr && (state == STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      shreg          <= '0;
      par            <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_err_parity <= 1'b0;
      out_err_frame  <= 1'b0;
      out_busy       <= 1'b0;
    end else begin
      out_valid      <= 1'b0;
      out_err_parity <= 1'b0;
      out_err_frame  <= 1'b0;
      if (in_clr) begin
        state    <= IDLE;
        cnt      <= 2'd0;
        shreg    <= '0;
        par      <= 1'b0;
        out_busy <= 1'b0;
      end else if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_bit == START_BIT) begin
              state    <= DATA;
              cnt      <= 2'd0;
              out_busy <= 1'b1;
            end
          end
          DATA: begin
            shreg[cnt] <= in_bit;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) state <= PARITY;
          end
          PARITY: begin
            par   <= in_bit;
            state <= STOP;
          end
          STOP: begin
            state    <= IDLE;
            out_busy <= 1'b0;
            if (in_bit == STOP_BIT) begin
              out_valid      <= 1'b1;
              out_data       <= shreg;
              out_err_parity <= par_err;
            end else begin
              out_err_frame <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PARITY_RX_ERR_CNT_EN
  // Updates on the same edge that registers the error pulse; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_cnt <= 8'h00;
    end else if (stop_take && ((in_bit != STOP_BIT) || par_err) && (out_err_cnt != 8'hFF)) begin
      out_err_cnt <= out_err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_parity_rx.sv
// tb/tb_parity_rx.sv - randomized scoreboard bench for parity_rx
module tb_parity_rx;

  localparam bit ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_clr;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_err_parity;
  logic       out_err_frame;
  logic       out_busy;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] out_err_cnt;
`endif

  parity_rx #(.PARITY_ODD(ODD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_clr         (in_clr),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_err_parity (out_err_parity),
    .out_err_frame  (out_err_frame),
    .out_busy       (out_busy)
`ifdef PARITY_RX_ERR_CNT_EN
    ,
    .out_err_cnt    (out_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_good = 4'h0;
  int         model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding frame expectation
  always @(negedge clk) begin
    if (rst_n && (out_valid || out_err_frame || out_err_parity)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual valid=%0b perr=%0b ferr=%0b expected none",
                 out_valid, out_err_parity, out_err_frame);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("out_valid", out_valid, e.valid);
        chk("out_err_parity", out_err_parity, e.perr);
        chk("out_err_frame", out_err_frame, e.ferr);
        chk("out_data", out_data, e.data);
`ifdef PARITY_RX_ERR_CNT_EN
        if (e.perr || e.ferr) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
        chk("out_err_cnt", out_err_cnt, model_cnt);
`endif
      end
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_clr   = 1'b0;
    in_bit   = 1'($urandom);
  endtask

  task automatic send_bit(input logic b, input int gap, output int samp);
    repeat (gap) idle_cycle();
    @(negedge clk);
    in_valid = 1'b1;
    in_clr   = 1'b0;
    in_bit   = b;
    samp     = cyc + 1;
  endtask

  // clr_at < 0: full frame; otherwise in_clr replaces the bit at that frame position
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            input int gap, input int clr_at);
    logic [6:0] bits;
    int         samp;
    exp_t       e;
    bits = {s, p, d[3], d[2], d[1], d[0], 1'b0};
    samp = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == clr_at) begin
        repeat (gap) idle_cycle();
        @(negedge clk);
        in_clr   = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        return;
      end
      send_bit(bits[i], gap, samp);
    end
    if (s) begin
      e.valid   = 1'b1;
      e.data    = d;
      e.perr    = (($countones(d) + int'(p)) % 2) != int'(ODD);
      e.ferr    = 1'b0;
      last_good = d;
    end else begin
      e.valid = 1'b0;
      e.data  = last_good;
      e.perr  = 1'b0;
      e.ferr  = 1'b1;
    end
    e.cyc = samp;
    sb.push_back(e);
  endtask

  initial begin
    int samp;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_err_parity", out_err_parity, 1'b0);
    chk("rst_out_err_frame", out_err_frame, 1'b0);
    chk("rst_out_busy", out_busy, 1'b0);
`ifdef PARITY_RX_ERR_CNT_EN
    chk("rst_out_err_cnt", out_err_cnt, 8'h00);
`endif
    rst_n = 1'b1;
    idle_cycle();

    send_frame(4'hD, 1'b1, 1'b1, 0, -1);
    send_frame(4'h5, 1'b0, 1'b0, 0, -1);
    send_frame(4'h0, 1'b1, 1'b1, 0, -1);
    repeat (2) idle_cycle();

    send_frame(4'h6, 1'b0, 1'b1, 3, 3);
    send_frame(4'hA, 1'b0, 1'b1, 3, -1);
    repeat (3) idle_cycle();

    for (int n = 0; n < 200; n++) begin
      int lead;
      int gap;
      int clr_at;
      lead   = $urandom_range(0, 2);
      gap    = $urandom_range(0, 2);
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
      for (int j = 0; j < lead; j++) send_bit(1'b1, gap, samp);
      send_frame(4'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), gap, clr_at);
    end
    repeat (5) idle_cycle();

    send_bit(1'b0, 0, samp);
    for (int j = 0; j < 4; j++) send_bit(1'($urandom), 0, samp);
    send_bit(1'b1, 0, samp);
    idle_cycle();
    chk("busy_mid_frame", out_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("busy_in_reset", out_busy, 1'b0);
    chk("data_in_reset", out_data, 4'h0);
    last_good = 4'h0;
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 0, samp);
    repeat (4) idle_cycle();
    chk("busy_after_rst", out_busy, 1'b0);
    chk("data_after_rst", out_data, 4'h0);

`ifdef PARITY_RX_ERR_CNT_EN
    for (int n = 0; n < 300; n++) send_frame(4'($urandom), 1'($urandom), 1'b0, 0, -1);
    repeat (3) idle_cycle();
    chk("err_cnt_saturated", out_err_cnt, 8'hFF);
    in_clr = 1'b1;
    @(negedge clk);
    in_clr = 1'b0;
    chk("err_cnt_after_clr", out_err_cnt, 8'hFF);
`endif

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle_cycle();
    chk("scoreboard_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
